// File: rtl/axil_pkg.sv
// AXI4-Lite shared constants and helpers.
// Used by both the read and write register-bank controllers.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axil_resp_fifo.sv
// In-order response FIFO for the AXI4-Lite read channel.
// Head data reads as zero while the FIFO is empty.
module axil_resp_fifo
  import axil_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axil_read_pipe.sv
// Pipelined AXI4-Lite read controller for generated register banks.
// Optional read-side-effect strobe enabled by `define READ_STROBE_EN.
module axil_read_pipe
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int DEPTH      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata
`ifdef READ_STROBE_EN
  ,
  output logic                           rd_strobe,
  output logic [idx_width(NUM_REGS)-1:0] rd_index
`endif
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = idx_width(NUM_REGS);
  localparam int FW       = DATA_WIDTH + 2;

  logic [IDX_W-1:0]      idx;
  logic                  hi_set;
  logic                  oor;
  logic [DATA_WIDTH-1:0] sel;
  logic [FW-1:0]         din;
  logic [FW-1:0]         dout;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [$clog2(DEPTH):0] count;

  assign idx    = araddr[ADDR_LSB +: IDX_W];
  assign hi_set = |(araddr >> (ADDR_LSB + IDX_W));
  assign oor    = hi_set || (32'(idx) >= NUM_REGS);

  // Loop mux keeps the part-select inside the bus for any NUM_REGS.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) sel = reg_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign din = oor ? {{DATA_WIDTH{1'b0}}, RESP_SLVERR}
                   : {sel, RESP_OKAY};

  assign arready = !full && !reset;
  assign push    = arvalid && arready;
  assign pop     = rvalid && rready;

  axil_resp_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign rdata  = dout[FW-1:2];
  assign rresp  = dout[1:0];
  assign rvalid = !empty;

`ifdef READ_STROBE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_strobe <= 1'b0;
      rd_index  <= '0;
    end else begin
      rd_strobe <= push && !oor;
      rd_index  <= idx;
    end
  end
`endif

endmodule
